os_frame_ctrl: RTL and testbench
================================

# os_frame_ctrl

Frame-level controller for the overlap-save equalizer path. It tracks 2N-sample frames leaving `os_buffer` toward the FFT and the matching 2N-sample frames returning from the IFFT. It limits the number of frames in flight by asserting a hold toward the input side. It performs the overlap-save discard, forwarding only the last N samples of each IFFT frame downstream.

## Interface

**Parameters**
- `N`, 16 — block size; frames are 2N samples.
- `WN`, 9 — signed sample width, I and Q.
- `MAX_INFLIGHT`, 2 — maximum frames started at the FFT and not yet completed at the IFFT; range 1..7.

**Ports** (clock and reset first)
- `i_clk` in 1 — single clock, rising edge.
- `i_rst` in 1 — synchronous, active-high reset.
- `i_fft_start` in 1 — first-sample strobe of an `os_buffer` output frame.
- `i_fft_valid` in 1 — `os_buffer` output sample valid.
- `i_ifft_start` in 1 — first-sample strobe of an IFFT output frame.
- `i_ifft_valid` in 1 — IFFT output sample valid.
- `i_ifft_xI`, `i_ifft_xQ` in WN — signed IFFT output samples.
- `o_hold` out 1 — registered; high means the upstream must not start a new frame.
- `o_inflight` out 3 — registered count of frames in flight.
- `o_out_valid` out 1 — registered; kept-sample valid.
- `o_out_xI`, `o_out_xQ` out WN — registered kept samples.
- `o_out_last` out 1 — high with the N-th kept sample of a frame.
- `o_frame_cnt` out 16 — completed IFFT frames; wraps at 2^16.
- `o_err` out 1 — sticky protocol error.

## Operation

**FFT-side counter** `fcnt` (0..2N-1):
- Increments on `i_fft_valid`.
- `i_fft_start` with `i_fft_valid` begins a frame and increments `inflight`.
- `fcnt` returns to 0 after the 2N-th valid.

**IFFT-side FSM**, states IDLE, DISCARD, KEEP:
- IDLE → DISCARD on `i_ifft_start & i_ifft_valid`. That sample is discard index 0.
- DISCARD counts valids `icnt` 0..N-1. The N-th valid moves the FSM to KEEP. No output is produced in DISCARD.
- KEEP forwards each valid sample: `o_out_valid=1` and data copied unchanged (no arithmetic).
- The N-th kept sample asserts `o_out_last`, increments `o_frame_cnt`, decrements `inflight`, and returns the FSM to IDLE.
- Gaps (valid low) are allowed in every state. Counters hold during gaps.

**In-flight accounting**:
- Frame start on the FFT side and frame completion on the IFFT side in the same cycle: `inflight` is unchanged.
- `o_hold` = (`inflight_next` ≥ `MAX_INFLIGHT`).

**Boundary conditions**:
- Completion with `inflight`=0 sets `o_err`; `inflight` stays 0.
- Start while `o_hold`=1 sets `o_err`; `inflight` still increments, saturating at 7.
- `i_ifft_start` in DISCARD or KEEP (see Configuration).

**Reset**:
- Applies at any time, including mid-frame.
- Sets all counters to 0, FSM to IDLE, and all outputs to 0.
- A frame partially received at reset is dropped. The next `i_ifft_start` begins a new frame.

## Timing

- Output latency: kept sample at cycle t appears on `o_out_*` at t+1.
- `o_hold` and `o_inflight` update on the edge that accepts the start or completion sample, and are visible the following cycle.
- `o_err` rises the cycle after the offending sample. It clears only on reset.
- Back-to-back frames: `i_ifft_start` is accepted in the cycle immediately after the last kept sample, with no idle cycle required.
- Throughput: one sample per clock.

## Configuration

Macro `OS_FRAME_CTRL_LENCHK_EN`.

**Defined:**
- `i_ifft_start` while the FSM is in DISCARD or KEEP sets `o_err`.
- The FSM resynchronizes to DISCARD with `icnt`=0, and that sample is discard index 0.
- `i_fft_start` with `fcnt`≠0 sets `o_err` and restarts `fcnt` at 1.
- The aborted partial IFFT frame does not decrement `inflight` and does not produce `o_out_last`.

**Undefined:**
- Starts are honored only in IDLE (IFFT) and at `fcnt`=0 (FFT). Mid-frame starts are ignored.
- Only the underflow and overflow error conditions from Operation drive `o_err`.

## Test plan

Test configuration: N=16, WN=9, `MAX_INFLIGHT`=2.

1. **Basic frame.** One FFT frame, then an IFFT frame with I=k, Q=-k for k=0..31, contiguous.
   - Required: 16 outputs carrying I=16..31, Q=-16..-31, each one cycle after input.
   - Required: `o_out_last` with I=31; `o_frame_cnt`=1; `inflight` back to 0; `o_err`=0.
2. **Hold.** Two FFT frames started with no IFFT activity.
   - Required: `o_inflight`=2 and `o_hold`=1 after the second start.
   - Completing one IFFT frame gives `o_hold`=0 and `o_inflight`=1.
3. **Gaps and simultaneity.** IFFT valid toggling every other cycle.
   - Required: exactly 16 outputs with no duplicates.
   - An FFT start on the same cycle as the 32nd IFFT sample leaves `inflight` unchanged.
4. **Errors.** IFFT frame completes with `inflight`=0.
   - Required: `o_err`=1 and it stays high.
   - FFT start while `o_hold`=1 sets `o_err`=1.
5. **Mid-frame start.** `i_ifft_start` at IFFT index 20.
   - With the macro defined: `o_err`=1, 4 samples forwarded before the restart, then a full 16-sample frame.
   - With the macro undefined: start ignored, 16 outputs, `o_err`=0.
6. **Reset mid-frame.** `i_rst` pulsed at KEEP index 5.
   - Required: all outputs 0 the next cycle.
   - The following clean frame yields 16 correct outputs and `o_frame_cnt`=1.

Source files
------------

// File: rtl/os_frame_ctrl.sv
// Overlap-save frame controller: FFT/IFFT frame tracking, in-flight hold and first-half discard.
// Optional macro OS_FRAME_CTRL_LENCHK_EN turns mid-frame starts into resync + sticky error.
module os_frame_ctrl #(
  parameter int N            = 16,
  parameter int WN           = 9,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_fft_start,
  input  logic          i_fft_valid,
  input  logic          i_ifft_start,
  input  logic          i_ifft_valid,
  input  logic [WN-1:0] i_ifft_xI,
  input  logic [WN-1:0] i_ifft_xQ,
  output logic          o_hold,
  output logic [2:0]    o_inflight,
  output logic          o_out_valid,
  output logic [WN-1:0] o_out_xI,
  output logic [WN-1:0] o_out_xQ,
  output logic          o_out_last,
  output logic [15:0]   o_frame_cnt,
  output logic          o_err
);

  localparam int FW = $clog2(2 * N);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, DISCARD, KEEP} state_t;

  state_t        state, state_next;
  logic [FW-1:0] fcnt;
  logic [IW-1:0] icnt, icnt_next;
  logic [2:0]    inflight_next;
  logic          fft_begin, fft_restart, fft_frame;
  logic          ifft_restart, keep_sample, frame_done;
  logic          underflow, overflow, err_set;

  // A mid-frame start only counts as a restart when length checking is built in.
  always_comb begin
    fft_begin = i_fft_start & i_fft_valid & (fcnt == '0);
`ifdef OS_FRAME_CTRL_LENCHK_EN
    fft_restart  = i_fft_start & i_fft_valid & (fcnt != '0);
    ifft_restart = i_ifft_start & i_ifft_valid & (state != IDLE);
`else
    fft_restart  = 1'b0;
    ifft_restart = 1'b0;
`endif
    fft_frame = fft_begin | fft_restart;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      icnt  <= '0;
    end else begin
      state <= state_next;
      icnt  <= icnt_next;
    end
  end

  // The start sample itself is discard index 0, so DISCARD is entered with icnt already at 1.
  always_comb begin
    state_next = state;
    icnt_next  = icnt;
    if (ifft_restart) begin
      state_next = DISCARD;
      icnt_next  = IW'(1);
    end else if (i_ifft_valid) begin
      case (state)
        IDLE: begin
          if (i_ifft_start) begin
            state_next = DISCARD;
            icnt_next  = IW'(1);
          end
        end
        DISCARD: begin
          if (icnt == IW'(N - 1)) begin
            state_next = KEEP;
            icnt_next  = '0;
          end else begin
            icnt_next = icnt + IW'(1);
          end
        end
        KEEP: begin
          if (icnt == IW'(N - 1)) begin
            state_next = IDLE;
            icnt_next  = '0;
          end else begin
            icnt_next = icnt + IW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          icnt_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    keep_sample = (state == KEEP) & i_ifft_valid & ~ifft_restart;
    frame_done  = keep_sample & (icnt == IW'(N - 1));
  end

  // Simultaneous start and completion cancel; underflow pins at 0, overflow saturates at 7.
  always_comb begin
    inflight_next = o_inflight;
    underflow     = 1'b0;
    if (fft_frame & ~frame_done) begin
      if (o_inflight != 3'd7) inflight_next = o_inflight + 3'd1;
    end else if (frame_done & ~fft_frame) begin
      if (o_inflight == 3'd0) underflow = 1'b1;
      else                    inflight_next = o_inflight - 3'd1;
    end
    overflow = fft_frame & o_hold;
    err_set  = underflow | overflow | fft_restart | ifft_restart;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fcnt        <= '0;
      o_inflight  <= '0;
      o_hold      <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_xI    <= '0;
      o_out_xQ    <= '0;
      o_out_last  <= 1'b0;
      o_frame_cnt <= '0;
      o_err       <= 1'b0;
    end else begin
      if (fft_restart)
        fcnt <= FW'(1);
      else if (i_fft_valid)
        fcnt <= (fcnt == FW'(2 * N - 1)) ? '0 : fcnt + FW'(1);
      o_inflight  <= inflight_next;
      o_hold      <= (inflight_next >= 3'(MAX_INFLIGHT));
      o_out_valid <= keep_sample;
      o_out_last  <= frame_done;
      if (keep_sample) begin
        o_out_xI <= i_ifft_xI;
        o_out_xQ <= i_ifft_xQ;
      end
      if (frame_done) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (err_set)    o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_os_frame_ctrl.sv
// Directed bench for os_frame_ctrl (N=16, WN=9, MAX_INFLIGHT=2).
module tb_os_frame_ctrl;
  localparam int N  = 16;
  localparam int WN = 9;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_fft_start, i_fft_valid, i_ifft_start, i_ifft_valid;
  logic [WN-1:0] i_ifft_xI, i_ifft_xQ;
  logic          o_hold, o_out_valid, o_out_last, o_err;
  logic [2:0]    o_inflight;
  logic [WN-1:0] o_out_xI, o_out_xQ;
  logic [15:0]   o_frame_cnt;

  int total = 0;
  int bad   = 0;

  os_frame_ctrl #(.N(N), .WN(WN), .MAX_INFLIGHT(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_fft_start(i_fft_start), .i_fft_valid(i_fft_valid),
    .i_ifft_start(i_ifft_start), .i_ifft_valid(i_ifft_valid),
    .i_ifft_xI(i_ifft_xI), .i_ifft_xQ(i_ifft_xQ),
    .o_hold(o_hold), .o_inflight(o_inflight),
    .o_out_valid(o_out_valid), .o_out_xI(o_out_xI), .o_out_xQ(o_out_xQ),
    .o_out_last(o_out_last), .o_frame_cnt(o_frame_cnt), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumed them.
  task automatic applyStimulus(input logic fs, input logic fv, input logic is, input logic iv,
                               input int xi, input int xq);
    i_fft_start  = fs;
    i_fft_valid  = fv;
    i_ifft_start = is;
    i_ifft_valid = iv;
    i_ifft_xI    = xi[WN-1:0];
    i_ifft_xQ    = xq[WN-1:0];
    @(posedge i_clk);
    #1;
  endtask

  task automatic fftFrame(input int cycles, input bit withStart);
    for (int i = 0; i < cycles; i++) applyStimulus(withStart && i == 0, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_hold"}, o_hold, 0);
    checkOutput({tag, "_inflight"}, o_inflight, 0);
    checkOutput({tag, "_valid"}, o_out_valid, 0);
    checkOutput({tag, "_xI"}, o_out_xI, 0);
    checkOutput({tag, "_xQ"}, o_out_xQ, 0);
    checkOutput({tag, "_last"}, o_out_last, 0);
    checkOutput({tag, "_fcnt"}, o_frame_cnt, 0);
    checkOutput({tag, "_err"}, o_err, 0);
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    i_rst = 1'b0;
  endtask

  // One IFFT frame with I=k, Q=-k; pos is the index within the frame the DUT should be tracking.
  task automatic ifftFrame(input int restartAt, input bit gaps, input bit fftAtLast);
    int  pos = 0;
    int  k = 0;
    int  outs = 0;
    int  expOuts = 16;
    bit  done = 0;
    int  obsI, obsQ;
`ifdef OS_FRAME_CTRL_LENCHK_EN
    if (restartAt > 16) expOuts = 16 + (restartAt - 16);
`endif
    while (!done) begin
`ifdef OS_FRAME_CTRL_LENCHK_EN
      if (k == restartAt) pos = 0;
`endif
      applyStimulus(fftAtLast && pos == 31, fftAtLast && pos == 31,
                    (k == 0) || (k == restartAt), 1'b1, k, -k);
      obsI = $signed(o_out_xI);
      obsQ = $signed(o_out_xQ);
      if (pos >= 16) begin
        checkOutput("keep_valid", o_out_valid, 1);
        checkOutput("keep_xI", obsI, k);
        checkOutput("keep_xQ", obsQ, -k);
        checkOutput("keep_last", o_out_last, (pos == 31) ? 1 : 0);
      end else begin
        checkOutput("discard_valid", o_out_valid, 0);
      end
      if (o_out_valid) outs++;
      done = (pos == 31);
      pos++;
      k++;
      if (gaps && !done) begin
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("gap_valid", o_out_valid, 0);
        if (o_out_valid) outs++;
      end
    end
    checkOutput("out_count", outs, expOuts);
  endtask

  initial begin
    i_rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    i_rst = 1'b0;
    checkAllZero("reset");

    $display("[TB] basic frame");
    fftFrame(32, 1);
    checkOutput("t1_inflight_up", o_inflight, 1);
    checkOutput("t1_hold_low", o_hold, 0);
    ifftFrame(-1, 0, 0);
    checkOutput("t1_frame_cnt", o_frame_cnt, 1);
    checkOutput("t1_inflight_down", o_inflight, 0);
    checkOutput("t1_err", o_err, 0);

    $display("[TB] hold");
    fftFrame(32, 1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("t2_inflight2", o_inflight, 2);
    checkOutput("t2_hold_high", o_hold, 1);
    fftFrame(31, 0);
    ifftFrame(-1, 0, 0);
    checkOutput("t2_hold_release", o_hold, 0);
    checkOutput("t2_inflight1", o_inflight, 1);

    $display("[TB] gaps and simultaneity");
    ifftFrame(-1, 1, 1);
    checkOutput("t3_inflight_same", o_inflight, 1);
    checkOutput("t3_hold", o_hold, 0);
    checkOutput("t3_frame_cnt", o_frame_cnt, 3);
    fftFrame(31, 0);

    $display("[TB] errors");
    ifftFrame(-1, 0, 0);
    checkOutput("t4_inflight0", o_inflight, 0);
    checkOutput("t4_err_pre", o_err, 0);
    ifftFrame(-1, 0, 0);
    checkOutput("t4_underflow_err", o_err, 1);
    checkOutput("t4_underflow_inflight", o_inflight, 0);
    checkOutput("t4_underflow_fcnt", o_frame_cnt, 5);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4_err_sticky", o_err, 1);
    doReset();
    checkOutput("t4_err_cleared", o_err, 0);
    fftFrame(32, 1);
    fftFrame(32, 1);
    checkOutput("t4_hold_set", o_hold, 1);
    checkOutput("t4_err_before_ovf", o_err, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("t4_overflow_err", o_err, 1);
    checkOutput("t4_overflow_inflight", o_inflight, 3);

    $display("[TB] mid-frame start");
    doReset();
    fftFrame(32, 1);
    ifftFrame(20, 0, 0);
`ifdef OS_FRAME_CTRL_LENCHK_EN
    checkOutput("t5_err", o_err, 1);
`else
    checkOutput("t5_err", o_err, 0);
`endif
    checkOutput("t5_inflight", o_inflight, 0);
    checkOutput("t5_frame_cnt", o_frame_cnt, 1);

    $display("[TB] reset mid-frame");
    doReset();
    fftFrame(32, 1);
    for (int k = 0; k <= 20; k++) applyStimulus(0, 0, k == 0, 1'b1, k, -k);
    checkOutput("t6_pre_valid", o_out_valid, 1);
    i_rst = 1'b1;
    applyStimulus(0, 0, 0, 1'b1, 21, -21);
    i_rst = 1'b0;
    checkAllZero("t6_reset");
    fftFrame(32, 1);
    ifftFrame(-1, 0, 0);
    checkOutput("t6_frame_cnt", o_frame_cnt, 1);
    checkOutput("t6_inflight", o_inflight, 0);
    checkOutput("t6_err", o_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
